// File: rtl/ocp_copy_master_pkg.sv
// Shared constants for the OCP word-copy master: bus widths, OCP command and
// response encodings, and the word-alignment helper.
package ocp_copy_master_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BEN_WIDTH  = DATA_WIDTH / 8;

  localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
  localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
  localparam logic [2:0] OCP_CMD_READ  = 3'b010;

  localparam logic [1:0] OCP_RESP_NULL = 2'b00;
  localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
  localparam logic [1:0] OCP_RESP_FAIL = 2'b10;
  localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  // Byte address rounded down to its 32-bit word.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/ocp_copy_master_if.sv
// OCP request/response bundle between the copy master and its slave.
interface ocp_copy_master_if import ocp_copy_master_pkg::*; ;

  logic [ADDR_WIDTH-1:0] o_MAddr;
  logic [2:0]            o_MCmd;
  logic [DATA_WIDTH-1:0] o_MData;
  logic [BEN_WIDTH-1:0]  o_MByteEn;
  logic                  i_SCmdAccept;
  logic [DATA_WIDTH-1:0] i_SData;
  logic [1:0]            i_SResp;

  modport master (
    output o_MAddr, o_MCmd, o_MData, o_MByteEn,
    input  i_SCmdAccept, i_SData, i_SResp
  );

  modport slave (
    input  o_MAddr, o_MCmd, o_MData, o_MByteEn,
    output i_SCmdAccept, i_SData, i_SResp
  );

endinterface

// File: rtl/ocp_copy_master.sv
// Word-by-word memory copy over OCP: one READ, then one WRITE of the returned
// data, per 32-bit word, until the count is exhausted or the slave errors.
module ocp_copy_master
  import ocp_copy_master_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [ADDR_WIDTH-1:0] i_dst,
  input  logic [CNT_WIDTH-1:0]  i_count,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  ocp_copy_master_if.master     ocp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_e;

  state_e                state;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_WIDTH-1:0]  remaining;

  // The data register is the write-data bus, so it holds between words.
  assign ocp.o_MData = data_q;

  // NOTE: every register here is state, so all assignments are non-blocking;
  // blocking ones would let later statements see mid-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      data_q        <= '0;
      remaining     <= '0;
      ocp.o_MCmd    <= OCP_CMD_IDLE;
      ocp.o_MAddr   <= '0;
      ocp.o_MByteEn <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            src_q     <= word_align(i_src);
            dst_q     <= word_align(i_dst);
            remaining <= i_count;
            o_err     <= 1'b0;
            o_busy    <= 1'b1;
            if (i_count == '0) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state       <= S_RD_REQ;
              ocp.o_MCmd  <= OCP_CMD_READ;
              ocp.o_MAddr <= word_align(i_src);
            end
          end
        end

        S_RD_REQ: begin
          if (ocp.i_SCmdAccept) begin
            state      <= S_RD_WAIT;
            ocp.o_MCmd <= OCP_CMD_IDLE;
          end
        end

        S_RD_WAIT: begin
          if (ocp.i_SResp == OCP_RESP_DVA) begin
            data_q        <= ocp.i_SData;
            state         <= S_WR_REQ;
            ocp.o_MCmd    <= OCP_CMD_WRITE;
            ocp.o_MAddr   <= dst_q;
            ocp.o_MByteEn <= '1;
          end else if (ocp.i_SResp == OCP_RESP_ERR || ocp.i_SResp == OCP_RESP_FAIL) begin
            o_err  <= 1'b1;
            state  <= S_DONE;
            o_done <= 1'b1;
          end
        end

        S_WR_REQ: begin
          if (ocp.i_SCmdAccept) begin
            state         <= S_WR_WAIT;
            ocp.o_MCmd    <= OCP_CMD_IDLE;
            ocp.o_MByteEn <= '0;
          end
        end

        S_WR_WAIT: begin
          if (ocp.i_SResp == OCP_RESP_DVA) begin
            // Address arithmetic wraps at the top of the address space.
            src_q     <= src_q + ADDR_WIDTH'(4);
            dst_q     <= dst_q + ADDR_WIDTH'(4);
            remaining <= remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state       <= S_RD_REQ;
              ocp.o_MCmd  <= OCP_CMD_READ;
              ocp.o_MAddr <= src_q + ADDR_WIDTH'(4);
            end
          end else if (ocp.i_SResp == OCP_RESP_ERR || ocp.i_SResp == OCP_RESP_FAIL) begin
            o_err  <= 1'b1;
            state  <= S_DONE;
            o_done <= 1'b1;
          end
        end

        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ocp_copy_master.md
OCP_COPY_MASTER -- requirements
Module: ocp_copy_master

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the word-count input and the internal remaining counter.
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port i_start, input, 1 bit: start pulse, sampled only in IDLE.
REQ-006 SHALL have port i_src, input, ADDR_WIDTH bits: source byte address.
REQ-007 SHALL have port i_dst, input, ADDR_WIDTH bits: destination byte address.
REQ-008 SHALL have port i_count, input, CNT_WIDTH bits: number of 32-bit words to copy.
REQ-009 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port o_err, output, 1 bit: sticky error flag, cleared by the next accepted start.
REQ-012 SHALL have OCP master ports o_MAddr (ADDR_WIDTH), o_MCmd (3), o_MData (DATA_WIDTH), o_MByteEn (BEN_WIDTH), all outputs.
REQ-013 SHALL have OCP master ports i_SCmdAccept (1), i_SData (DATA_WIDTH), i_SResp (2), all inputs.

Function
REQ-014 SHALL implement the states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT and DONE.
REQ-015 IDLE: on i_start, SHALL latch i_src and i_dst with bits [1:0] forced to 0, latch i_count, clear o_err, and go to RD_REQ; if i_count==0, SHALL go to DONE instead.
REQ-016 RD_REQ: SHALL drive o_MCmd=OCP_CMD_READ and o_MAddr=current source, holding both stable until i_SCmdAccept=1, then go to RD_WAIT.
REQ-017 RD_WAIT: SHALL drive OCP_CMD_IDLE; on i_SResp=OCP_RESP_DVA, SHALL capture i_SData into the data register and go to WR_REQ.
REQ-018 WR_REQ: SHALL drive o_MCmd=OCP_CMD_WRITE, o_MAddr=current destination, o_MData=data register and o_MByteEn all ones, holding all stable until i_SCmdAccept=1, then go to WR_WAIT.
REQ-019 WR_WAIT: on DVA, SHALL add 4 to the source and destination addresses (modulo 2^ADDR_WIDTH, wrapping silently) and decrement the remaining counter; if remaining was 1, SHALL go to DONE, otherwise to RD_REQ.
REQ-020 RD_WAIT/WR_WAIT: on OCP_RESP_ERR or OCP_RESP_FAIL, SHALL set o_err and go to DONE without further bus commands.
REQ-021 i_SResp SHALL be ignored in IDLE, RD_REQ, WR_REQ and DONE; i_SCmdAccept SHALL be ignored outside the REQ states.
REQ-022 DONE: SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-023 i_start while busy SHALL be ignored, with no effect on the latched parameters.
REQ-024 Outside the REQ states, o_MCmd SHALL be OCP_CMD_IDLE, o_MByteEn 0 and o_MAddr/o_MData held at their last values.
REQ-025 With a responder that always accepts and answers one cycle later, each word SHALL take exactly 4 cycles; N words SHALL take 4N+1 cycles from the start cycle to o_done.

Reset
REQ-026 rst SHALL force IDLE, o_MCmd=OCP_CMD_IDLE, o_MAddr=0, o_MData=0, o_MByteEn=0, o_busy=0, o_done=0, o_err=0 and clear the counters, address registers and data register.
REQ-027 rst mid-transfer SHALL abort immediately with no o_done pulse; a response arriving after reset SHALL be ignored.

Structure
REQ-028 OCP command/response encodings SHALL come from ocp_const.vh; ADDR_WIDTH, DATA_WIDTH and BEN_WIDTH SHALL come from common.vh; state encodings SHALL be local to the module.
REQ-029 The block SHALL be a single module with no sub-modules.

Verification
REQ-030 Check: src=0x100, dst=0x2000, count=3, against a rom_top-like responder -> READs 0x100/0x104/0x108, WRITEs of the same data to 0x2000/0x2004/0x2008, o_done at cycle 13, o_err=0.
REQ-031 Check: count=0 -> no bus command, o_done pulses in the cycle after start.
REQ-032 Check: i_SCmdAccept held low for 3 cycles on the first READ -> command and address held stable for 4 cycles, data still correct.
REQ-033 Check: ERR response on the second read -> o_err=1, o_done pulses, exactly one WRITE issued.
REQ-034 Check: src=0xFFFFFFFC, count=2 -> second READ goes to 0x00000000.
REQ-035 Check: rst asserted in WR_WAIT, then a late DVA -> IDLE, no o_done, DVA ignored; a new start then succeeds.
